// File: rtl/mouse_cursor_overlay_pkg.sv
// Shared definitions for the mouse cursor overlay.
// Contents: the click FSM state type, the OLED grid size, RGB565 colours,
// a clamp helper for the coordinate scaler and an arm-reach helper for the
// crosshair renderer.
package cursor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } click_state_e;

    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

    localparam logic [6:0] X_MAX = 7'(OLED_W - 1);
    localparam logic [6:0] Y_MAX = 7'(OLED_H - 1);

    localparam logic [15:0] RGB565_RED  = 16'hF800;
    localparam logic [15:0] RGB565_BLUE = 16'h001F;

    // Saturate a shifted product onto the visible grid.
    function automatic logic [6:0] scale_clamp(input logic [19:0] scaled,
                                               input logic [6:0]  max_v);
        logic [6:0] res;
        if (scaled > {13'd0, max_v}) begin
            res = max_v;
        end else begin
            res = scaled[6:0];
        end
        return res;
    endfunction

    // True when a signed pixel offset lies on a 2-pixel crosshair arm.
    function automatic logic within_arm(input logic signed [8:0] d);
        return (d >= -9'sd2) && (d <= 9'sd2);
    endfunction

endpackage

// File: rtl/mouse_cursor_overlay_if.sv
// Pixel-stream bundle between the frame generator and the OLED driver.
// Ports: frame_begin (frame-start strobe), pixel_x/pixel_y (current pixel),
// in_pixel_data (upstream RGB565), out_pixel_data (RGB565 to the display).
// The overlay is the slave: it consumes the stream and returns the pixel.
interface mouse_cursor_overlay_if;
    logic        frame_begin;
    logic [6:0]  pixel_x;
    logic [6:0]  pixel_y;
    logic [15:0] in_pixel_data;
    logic [15:0] out_pixel_data;

    modport master (
        output frame_begin, pixel_x, pixel_y, in_pixel_data,
        input  out_pixel_data
    );

    modport slave (
        input  frame_begin, pixel_x, pixel_y, in_pixel_data,
        output out_pixel_data
    );
endinterface

// File: rtl/mouse_cursor_overlay_button_debouncer.sv
// Debounces the raw mouse left button and produces click / long-press events.
// Ports: clock, reset_n (async active-low), enable (0 forces IDLE),
// mouse_left (raw button), cursor_x/cursor_y (live scaled cursor),
// button_held (debounced level), click_pulse with click_x/click_y latched on
// the same cycle, long_press_pulse (once per hold).
module button_debouncer
    import cursor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       mouse_left,
    input  logic [6:0] cursor_x,
    input  logic [6:0] cursor_y,
    output logic       button_held,
    output logic       click_pulse,
    output logic [6:0] click_x,
    output logic [6:0] click_y,
    output logic       long_press_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LP_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);

    logic btn_meta_r, btn_r;
    click_state_e state_r, state_nx;
    logic [DB_W-1:0] db_cnt_r, db_cnt_nx;
    logic [LP_W-1:0] hold_cnt_r, hold_cnt_nx;
    logic held_r, held_nx;
    logic click_r, click_nx;
    logic long_r, long_nx;
    logic [6:0] click_x_r, click_x_nx, click_y_r, click_y_nx;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_r <= 1'b0;
            btn_r      <= 1'b0;
        end else begin
            btn_meta_r <= mouse_left;
            btn_r      <= btn_meta_r;
        end
    end

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_nx    = state_r;
        db_cnt_nx   = db_cnt_r;
        hold_cnt_nx = hold_cnt_r;
        held_nx     = held_r;
        click_nx    = 1'b0;
        long_nx     = 1'b0;
        click_x_nx  = click_x_r;
        click_y_nx  = click_y_r;
        if (!enable) begin
            state_nx    = IDLE;
            db_cnt_nx   = '0;
            hold_cnt_nx = '0;
            held_nx     = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    db_cnt_nx = '0;
                    if (btn_r) begin
                        state_nx = PRESS_DB;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                PRESS_DB: begin
                    if (!btn_r) begin
                        state_nx  = IDLE;
                        db_cnt_nx = '0;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_nx    = HELD;
                        db_cnt_nx   = '0;
                        hold_cnt_nx = '0;
                        held_nx     = 1'b1;
                        click_nx    = 1'b1;
                        click_x_nx  = cursor_x;
                        click_y_nx  = cursor_y;
                    end else begin
                        db_cnt_nx = db_cnt_r + DB_ONE;
                    end
                end
                HELD: begin
                    if (!btn_r) begin
                        state_nx  = REL_DB;
                        db_cnt_nx = '0;
                    end else if (hold_cnt_r != LP_LAST) begin
                        // Counter saturates at LP_LAST, so the pulse fires once per hold.
                        hold_cnt_nx = hold_cnt_r + LP_ONE;
                        long_nx     = ((hold_cnt_r + LP_ONE) == LP_LAST);
                    end else begin
                        hold_cnt_nx = hold_cnt_r;
                    end
                end
                REL_DB: begin
                    if (btn_r) begin
                        // Release glitch: resume the hold without a new click.
                        state_nx  = HELD;
                        db_cnt_nx = '0;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_nx    = IDLE;
                        db_cnt_nx   = '0;
                        hold_cnt_nx = '0;
                        held_nx     = 1'b0;
                    end else begin
                        db_cnt_nx = db_cnt_r + DB_ONE;
                    end
                end
                default: begin
                    state_nx    = IDLE;
                    db_cnt_nx   = '0;
                    hold_cnt_nx = '0;
                    held_nx     = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counters and registered event outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            db_cnt_r   <= '0;
            hold_cnt_r <= '0;
            held_r     <= 1'b0;
            click_r    <= 1'b0;
            long_r     <= 1'b0;
            click_x_r  <= 7'd0;
            click_y_r  <= 7'd0;
        end else begin
            state_r    <= state_nx;
            db_cnt_r   <= db_cnt_nx;
            hold_cnt_r <= hold_cnt_nx;
            held_r     <= held_nx;
            click_r    <= click_nx;
            long_r     <= long_nx;
            click_x_r  <= click_x_nx;
            click_y_r  <= click_y_nx;
        end
    end

    assign button_held      = held_r;
    assign click_pulse      = click_r;
    assign click_x          = click_x_r;
    assign click_y          = click_y_r;
    assign long_press_pulse = long_r;

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Mouse cursor overlay between MouseCtl/ANIMATION and Oled_Display.
// Ports: clock, reset_n (async active-low), enable, mouse_x/mouse_y/mouse_left
// (raw MouseCtl), pix (pixel-stream slave: frame_begin, pixel_x, pixel_y,
// in_pixel_data in, out_pixel_data out), cursor_x/cursor_y (scaled live
// cursor), button_held, click_pulse, click_x/click_y, long_press_pulse.
// The drawn cursor position is sampled only at frame start to avoid tearing.
module mouse_cursor_overlay
    import cursor_pkg::*;
#(
    parameter int          X_MUL           = 77,
    parameter int          X_SHIFT         = 9,
    parameter int          Y_MUL           = 17,
    parameter int          Y_SHIFT         = 7,
    parameter int          DEBOUNCE_CYCLES = 100000,
    parameter int          LONG_CYCLES     = 50000000,
    parameter logic [15:0] CURSOR_COLOUR   = RGB565_RED
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [11:0]            mouse_x,
    input  logic [11:0]            mouse_y,
    input  logic                   mouse_left,
    mouse_cursor_overlay_if.slave  pix,
    output logic [6:0]             cursor_x,
    output logic [6:0]             cursor_y,
    output logic                   button_held,
    output logic                   click_pulse,
    output logic [6:0]             click_x,
    output logic [6:0]             click_y,
    output logic                   long_press_pulse
);

    logic [19:0] prod_x_s, prod_y_s;
    logic [6:0]  sx_s, sy_s;
    logic [6:0]  cursor_x_r, cursor_y_r;
    logic        fb_meta_r, fb_sync_r, fb_prev_r;
    logic        frame_rise_s;
    logic [6:0]  disp_x_r, disp_y_r;
    logic signed [8:0] dx_s, dy_s;
    logic        hit_s;

    // Fixed-point scale of raw mouse coordinates onto the 96x64 grid.
    always_comb begin
        prod_x_s = 20'(mouse_x) * 20'(X_MUL);
        prod_y_s = 20'(mouse_y) * 20'(Y_MUL);
        sx_s     = scale_clamp(prod_x_s >> X_SHIFT, X_MAX);
        sy_s     = scale_clamp(prod_y_s >> Y_SHIFT, Y_MAX);
    end

    // Register the scaled live cursor.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cursor_x_r <= 7'd0;
            cursor_y_r <= 7'd0;
        end else begin
            cursor_x_r <= sx_s;
            cursor_y_r <= sy_s;
        end
    end

    // Synchronise the slow-domain frame strobe and keep its previous value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fb_meta_r <= 1'b0;
            fb_sync_r <= 1'b0;
            fb_prev_r <= 1'b0;
        end else begin
            fb_meta_r <= pix.frame_begin;
            fb_sync_r <= fb_meta_r;
            fb_prev_r <= fb_sync_r;
        end
    end

    assign frame_rise_s = fb_sync_r & ~fb_prev_r;

    // Capture the drawn cursor position once per frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_x_r <= 7'd0;
            disp_y_r <= 7'd0;
        end else if (frame_rise_s) begin
            disp_x_r <= cursor_x_r;
            disp_y_r <= cursor_y_r;
        end else begin
            disp_x_r <= disp_x_r;
            disp_y_r <= disp_y_r;
        end
    end

    // Crosshair renderer; signed offsets keep arms from wrapping at edges.
    always_comb begin
        dx_s  = $signed({2'b00, pix.pixel_x}) - $signed({2'b00, disp_x_r});
        dy_s  = $signed({2'b00, pix.pixel_y}) - $signed({2'b00, disp_y_r});
        hit_s = enable &&
                (((pix.pixel_y == disp_y_r) && within_arm(dx_s)) ||
                 ((pix.pixel_x == disp_x_r) && within_arm(dy_s)));
        if (hit_s) begin
            pix.out_pixel_data = CURSOR_COLOUR;
        end else begin
            pix.out_pixel_data = pix.in_pixel_data;
        end
    end

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_button_debouncer (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .mouse_left       (mouse_left),
        .cursor_x         (cursor_x_r),
        .cursor_y         (cursor_y_r),
        .button_held      (button_held),
        .click_pulse      (click_pulse),
        .click_x          (click_x),
        .click_y          (click_y),
        .long_press_pulse (long_press_pulse)
    );

    assign cursor_x = cursor_x_r;
    assign cursor_y = cursor_y_r;

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Self-checking bench for mouse_cursor_overlay with short debounce/long-press
// times. Expected events are queued when stimulus is driven and checked
// against the DUT when it produces them.
module tb_mouse_cursor_overlay;
    import cursor_pkg::*;

    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [11:0] mouse_x;
    logic [11:0] mouse_y;
    logic        mouse_left;
    logic [6:0]  cursor_x, cursor_y, click_x, click_y;
    logic        button_held, click_pulse, long_press_pulse;

    mouse_cursor_overlay_if pix();

    mouse_cursor_overlay #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .mouse_x          (mouse_x),
        .mouse_y          (mouse_y),
        .mouse_left       (mouse_left),
        .pix              (pix.slave),
        .cursor_x         (cursor_x),
        .cursor_y         (cursor_y),
        .button_held      (button_held),
        .click_pulse      (click_pulse),
        .click_x          (click_x),
        .click_y          (click_y),
        .long_press_pulse (long_press_pulse)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        int         cyc;
        logic [6:0] x;
        logic [6:0] y;
    } ev_t;

    typedef struct packed {
        logic [6:0] x;
        logic [6:0] y;
    } xy_t;

    ev_t         click_q[$];
    int          long_q[$];
    xy_t         cur_q[$];
    logic [15:0] pix_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock; then compare any event pulse against the scoreboard.
    task automatic tick();
        ev_t e;
        int  lc;
        @(posedge clock);
        #1;
        cyc++;
        if (click_pulse === 1'b1) begin
            checks++;
            if (click_q.size() == 0) begin
                errors++;
                $display("FAIL click_unexpected: pulse at cycle %0d, none queued", cyc);
            end else begin
                e = click_q.pop_front();
                if (cyc != e.cyc || click_x !== e.x || click_y !== e.y) begin
                    errors++;
                    $display("FAIL click_event: got cycle %0d xy %0d,%0d, expected cycle %0d xy %0d,%0d",
                             cyc, click_x, click_y, e.cyc, e.x, e.y);
                end
            end
        end
        if (click_q.size() != 0 && click_q[0].cyc < cyc) begin
            e = click_q.pop_front();
            errors++;
            $display("FAIL click_missed: no pulse at cycle %0d", e.cyc);
        end
        if (long_press_pulse === 1'b1) begin
            checks++;
            if (long_q.size() == 0) begin
                errors++;
                $display("FAIL long_unexpected: pulse at cycle %0d, none queued", cyc);
            end else begin
                lc = long_q.pop_front();
                if (cyc != lc) begin
                    errors++;
                    $display("FAIL long_event: got cycle %0d, expected cycle %0d", cyc, lc);
                end
            end
        end
        if (long_q.size() != 0 && long_q[0] < cyc) begin
            lc = long_q.pop_front();
            errors++;
            $display("FAIL long_missed: no pulse at cycle %0d", lc);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b1;
        mouse_x = 12'd320;
        mouse_y = 12'd240;
        mouse_left = 1'b0;
        pix.frame_begin = 1'b0;
        pix.pixel_x = 7'd50;
        pix.pixel_y = 7'd50;
        pix.in_pixel_data = 16'h1234;
        repeat (3) tick();
        checks++;
        if ({cursor_x, cursor_y, click_x, click_y, button_held, click_pulse, long_press_pulse} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {cursor_x, cursor_y, click_x, click_y, button_held, click_pulse, long_press_pulse});
        end
        checks++;
        if (pix.out_pixel_data !== 16'h1234) begin
            errors++;
            $display("FAIL reset_pixel: got %h expected 1234", pix.out_pixel_data);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_scaling();
        int mx[5] = '{320, 639, 4095, 67, 0};
        int my[5] = '{240, 479, 4095, 151, 0};
        int ex[5] = '{48, 95, 95, 10, 0};
        int ey[5] = '{31, 63, 63, 20, 0};
        xy_t e;
        for (int i = 0; i < 5; i++) begin
            mouse_x = 12'(mx[i]);
            mouse_y = 12'(my[i]);
            cur_q.push_back({7'(ex[i]), 7'(ey[i])});
            tick();
            e = cur_q.pop_front();
            checks++;
            if (cursor_x !== e.x || cursor_y !== e.y) begin
                errors++;
                $display("FAIL scaling: mouse %0d,%0d got %0d,%0d expected %0d,%0d",
                         mx[i], my[i], cursor_x, cursor_y, e.x, e.y);
            end
        end
    endtask

    task automatic test_overlay();
        int px[6] = '{50, 48, 51, 48, 46, 48};
        int py[6] = '{31, 29, 31, 34, 31, 33};
        int ev[6] = '{16'hF800, 16'hF800, 16'h001F, 16'h001F, 16'hF800, 16'hF800};
        logic [15:0] exp_pix;
        mouse_x = 12'd320;
        mouse_y = 12'd240;
        pix.in_pixel_data = RGB565_BLUE;
        tick();
        pix.frame_begin = 1'b1;
        pix.pixel_x = 7'd48;
        pix.pixel_y = 7'd31;
        tick();
        tick();
        // Two cycles after the strobe the old position is still drawn.
        pix_q.push_back(16'h001F);
        exp_pix = pix_q.pop_front();
        checks++;
        if (pix.out_pixel_data !== exp_pix) begin
            errors++;
            $display("FAIL frame_latency_early: got %h expected %h", pix.out_pixel_data, exp_pix);
        end
        tick();
        pix_q.push_back(16'hF800);
        exp_pix = pix_q.pop_front();
        checks++;
        if (pix.out_pixel_data !== exp_pix) begin
            errors++;
            $display("FAIL frame_latency: got %h expected %h", pix.out_pixel_data, exp_pix);
        end
        tick();
        pix.frame_begin = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 6; i++) begin
                pix.pixel_x = 7'(px[i]);
                pix.pixel_y = 7'(py[i]);
                pix_q.push_back(16'(ev[i]));
                #1;
                exp_pix = pix_q.pop_front();
                checks++;
                if (pix.out_pixel_data !== exp_pix) begin
                    errors++;
                    $display("FAIL overlay_pixel: pass %0d pixel %0d,%0d got %h expected %h",
                             pass, px[i], py[i], pix.out_pixel_data, exp_pix);
                end
            end
            // Move the mouse without a frame strobe: drawing must not change.
            mouse_x = 12'd0;
            mouse_y = 12'd0;
            repeat (6) tick();
        end
    endtask

    task automatic test_edge_clip();
        int px[10] = '{0, 1, 2, 0, 0, 3, 0, 127, 95, 126};
        int py[10] = '{0, 0, 0, 1, 2, 0, 3, 0, 63, 0};
        int ev[10] = '{16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hF800,
                       16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F};
        logic [15:0] exp_pix;
        pix.frame_begin = 1'b1;
        repeat (4) tick();
        pix.frame_begin = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            pix.pixel_x = 7'(px[i]);
            pix.pixel_y = 7'(py[i]);
            pix_q.push_back(16'(ev[i]));
            #1;
            exp_pix = pix_q.pop_front();
            checks++;
            if (pix.out_pixel_data !== exp_pix) begin
                errors++;
                $display("FAIL edge_clip: pixel %0d,%0d got %h expected %h",
                         px[i], py[i], pix.out_pixel_data, exp_pix);
            end
        end
    endtask

    task automatic test_debounce();
        int c;
        logic exp_held;
        mouse_x = 12'd67;
        mouse_y = 12'd151;
        repeat (2) tick();
        // 3-cycle glitch: shorter than the debounce window.
        mouse_left = 1'b1;
        repeat (3) tick();
        mouse_left = 1'b0;
        repeat (10) tick();
        checks++;
        if (button_held !== 1'b0) begin
            errors++;
            $display("FAIL glitch_held: got %b expected 0", button_held);
        end
        // 10-cycle hold at cursor 10,20.
        c = cyc;
        mouse_left = 1'b1;
        click_q.push_back({c + 2 + DEB + 1, 7'd10, 7'd20});
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_held = (k >= 7 && k <= 16);
            checks++;
            if (button_held !== exp_held) begin
                errors++;
                $display("FAIL debounce_held: cycle +%0d got %b expected %b", k, button_held, exp_held);
            end
            if (k == 10) mouse_left = 1'b0;
        end
        checks++;
        if (click_q.size() != 0) begin
            errors++;
            $display("FAIL debounce_drain: got %0d queued clicks expected 0", click_q.size());
        end
    endtask

    task automatic test_long_press();
        int c;
        c = cyc;
        mouse_left = 1'b1;
        click_q.push_back({c + 7, 7'd10, 7'd20});
        long_q.push_back(c + 7 + LONG - 1);
        for (int k = 1; k <= 55; k++) begin
            tick();
            if (k == 28) mouse_left = 1'b0;
            if (k == 30) mouse_left = 1'b1;
            if (k == 35) begin
                checks++;
                if (button_held !== 1'b1) begin
                    errors++;
                    $display("FAIL long_glitch_held: got %b expected 1", button_held);
                end
            end
            if (k == 40) mouse_left = 1'b0;
        end
        checks++;
        if (click_q.size() != 0 || long_q.size() != 0 || button_held !== 1'b0) begin
            errors++;
            $display("FAIL long_drain: got clicks %0d longs %0d held %b expected 0 0 0",
                     click_q.size(), long_q.size(), button_held);
        end
    endtask

    task automatic test_enable();
        int c;
        c = cyc;
        mouse_left = 1'b1;
        click_q.push_back({c + 7, 7'd10, 7'd20});
        repeat (10) tick();
        pix.pixel_x = 7'd0;
        pix.pixel_y = 7'd0;
        pix.in_pixel_data = 16'h07E0;
        enable = 1'b0;
        #1;
        checks++;
        if (pix.out_pixel_data !== 16'h07E0) begin
            errors++;
            $display("FAIL enable_passthru: got %h expected 07e0", pix.out_pixel_data);
        end
        tick();
        checks++;
        if (button_held !== 1'b0) begin
            errors++;
            $display("FAIL enable_held: got %b expected 0", button_held);
        end
        mouse_x = 12'd320;
        mouse_y = 12'd240;
        repeat (8) tick();
        checks++;
        if (button_held !== 1'b0 || cursor_x !== 7'd48 || cursor_y !== 7'd31) begin
            errors++;
            $display("FAIL enable_disabled: got held %b cursor %0d,%0d expected 0 48,31",
                     button_held, cursor_x, cursor_y);
        end
        mouse_left = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (6) tick();
        checks++;
        if (pix.out_pixel_data !== 16'hF800 || button_held !== 1'b0 || click_q.size() != 0) begin
            errors++;
            $display("FAIL enable_resume: got pixel %h held %b clicks %0d expected f800 0 0",
                     pix.out_pixel_data, button_held, click_q.size());
        end
    endtask

    task automatic test_async_reset();
        int r;
        mouse_x = 12'd67;
        mouse_y = 12'd151;
        repeat (2) tick();
        mouse_left = 1'b1;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cursor_x, cursor_y, click_x, click_y, button_held, click_pulse, long_press_pulse} !== 31'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0",
                     {cursor_x, cursor_y, click_x, click_y, button_held, click_pulse, long_press_pulse});
        end
        repeat (2) tick();
        r = cyc;
        reset_n = 1'b1;
        click_q.push_back({r + 2 + DEB + 1, 7'd10, 7'd20});
        repeat (12) tick();
        mouse_left = 1'b0;
        repeat (10) tick();
        checks++;
        if (click_q.size() != 0 || button_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: got clicks %0d held %b expected 0 0",
                     click_q.size(), button_held);
        end
    endtask

    initial begin
        test_reset();
        test_scaling();
        test_overlay();
        test_edge_clip();
        test_debounce();
        test_long_press();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_cursor_overlay.md
Name: mouse_cursor_overlay

Overview:
Sits between MouseCtl/ANIMATION and Oled_Display. Maps raw 12-bit mouse coordinates onto the 96x64 OLED grid and turns the raw left button into debounced click and long-press events with latched OLED coordinates for game logic. Draws a 5x5 crosshair cursor over the incoming pixel stream. Cursor position updates only at frame start, so the cursor never tears mid-frame.

Parameters:
X_MUL, 77, x scale multiplier (oled_x = (mouse_x*X_MUL)>>X_SHIFT, 640 -> 96)
X_SHIFT, 9, x scale shift
Y_MUL, 17, y scale multiplier (480 -> 64)
Y_SHIFT, 7, y scale shift
DEBOUNCE_CYCLES, 100000, stable cycles needed to accept a press or release (1 ms at 100 MHz)
LONG_CYCLES, 50000000, held cycles before long_press_pulse (0.5 s)
CURSOR_COLOUR, 16'hF800, RGB565 cursor colour

Ports:
clock  in  1  100 MHz system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = overlay and events active; 0 = pass-through, FSM held in IDLE
mouse_x  in  12  raw MouseCtl x
mouse_y  in  12  raw MouseCtl y
mouse_left  in  1  raw MouseCtl left button
frame_begin  in  1  OLED frame-start strobe, 6.25 MHz domain
pixel_x  in  7  current OLED column, 0..95
pixel_y  in  7  current OLED row, 0..63
in_pixel_data  in  16  upstream RGB565 pixel
out_pixel_data  out  16  pixel to Oled_Display
cursor_x  out  7  scaled live cursor x
cursor_y  out  7  scaled live cursor y
button_held  out  1  debounced button level
click_pulse  out  1  one-cycle pulse on accepted press
click_x  out  7  cursor_x latched at click
click_y  out  7  cursor_y latched at click
long_press_pulse  out  1  one-cycle pulse after LONG_CYCLES held

Behaviour:
- Reset: every register clears to 0, including cursor_x/y, disp_x/y, click_x/y, pulses, button_held and counters. FSM goes to IDLE.
- Scaling, 1-cycle registered:
  - sx = (mouse_x*X_MUL)>>X_SHIFT, clamped to 95.
  - sy = (mouse_y*Y_MUL)>>Y_SHIFT, clamped to 63.
  - Products are computed at 20 bits, so no overflow.
  - mouse_x = 4095 clamps to 95.
- Frame latch:
  - frame_begin passes through a 2-flop synchroniser, then rising-edge detection.
  - On the edge, disp_x/disp_y <= cursor_x/cursor_y.
  - Overlay uses disp_* only.
- Overlay, combinational from registered state:
  - out = CURSOR_COLOUR when enable and (pixel_y == disp_y and |pixel_x - disp_x| <= 2) or (pixel_x == disp_x and |pixel_y - disp_y| <= 2).
  - Otherwise out = in_pixel_data.
  - Signed compare, so the arms clip at screen edges with no wrap-around (cursor at 0 draws nothing at x = 126/127).
- mouse_left passes through a 2-flop synchroniser before the FSM.
- Click FSM, 4 states:
  - IDLE: btn=1 -> PRESS_DB, counter cleared.
  - PRESS_DB: btn=0 -> IDLE. Counter reaching DEBOUNCE_CYCLES-1 -> HELD, click_pulse=1 for 1 cycle, click_x/y <= cursor_x/y that same cycle, button_held=1.
  - HELD: hold counter counts up. On reaching LONG_CYCLES-1, long_press_pulse fires once per hold and the counter saturates. btn=0 -> REL_DB.
  - REL_DB: btn=1 -> HELD (hold counter keeps its value, no new click). Counter reaching DEBOUNCE_CYCLES-1 -> IDLE, button_held=0.
- Press glitches shorter than DEBOUNCE_CYCLES produce no event.
- enable=0 mid-operation: FSM forces IDLE next cycle, counters clear, button_held=0, no pulses. Scaling and frame latch keep running.
- Latency:
  - mouse change to cursor_x: 1 cycle.
  - cursor_x to display: next frame edge plus 3 cycles.
  - Press to click_pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Decomposition:
- Package cursor_pkg: FSM state enum (IDLE, PRESS_DB, HELD, REL_DB), OLED_W = 96, OLED_H = 64, RGB565 colour constants.
- One sub-module: button_debouncer (synchroniser, FSM, counters, pulse outputs).
- Scaling, frame latch and overlay stay in the top.

Test Plan:
- Scaling: mouse_x = 320, mouse_y = 240 -> cursor 48,31 after 1 cycle. Next, 639,479 -> 95,63. Next, 4095,4095 -> 95,63 (clamped).
- Overlay: DEBOUNCE_CYCLES = 4; cursor 48,31, frame_begin pulse, in_pixel_data = 16'h001F. Then pixel 50,31 and 48,29 -> 16'hF800; pixel 51,31 -> 16'h001F. Moving the mouse without a new frame_begin leaves the drawing unchanged.
- Edge clip: cursor 0,0, then frame edge -> pixels 0..2 on row 0 and rows 0..2 on column 0 are cursor colour; pixel 127,0 and 95,63 pass through.
- Debounce: DEBOUNCE_CYCLES = 4; a 3-cycle mouse_left glitch -> no click_pulse. A 10-cycle hold at cursor 10,20 -> exactly one click_pulse with click_x = 10, click_y = 20, button_held = 1 until release is debounced.
- Long press: LONG_CYCLES = 16, held 40 cycles -> exactly one long_press_pulse. A 2-cycle release glitch mid-hold -> no extra click_pulse.
- Enable/reset: enable drops while in HELD -> button_held = 0 next cycle, out_pixel_data == in_pixel_data. reset_n asserted asynchronously mid-PRESS_DB -> all outputs 0 immediately, no click after reset_n is released while the button is still held until the full debounce time has elapsed.
